// File: rtl/multicycle_control_if.sv
// Handshake/bus bundle for the multicycle instruction sequencer.
// The master side drives run/opcode/mem_ready. The slave side (the controller)
// drives every datapath control strobe.
interface multicycle_control_if #(
    parameter int OPW  = 6,
    parameter int ALUW = 3
);
    logic            run;
    logic [OPW-1:0]  opcode;
    logic            mem_ready;
    logic            ir_write;
    logic            pc_write;
    logic [ALUW-1:0] alu_op;
    logic            alu_src;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            reg_write;
    logic            br_valid;
    logic [3:0]      br_code;
    logic [2:0]      state;
    logic            busy;
    logic            instr_done;
    logic            illegal;

    modport master (
        output run, opcode, mem_ready,
        input  ir_write, pc_write, alu_op, alu_src, mem_read, mem_write,
               mem_to_reg, reg_write, br_valid, br_code, state, busy,
               instr_done, illegal
    );

    modport slave (
        input  run, opcode, mem_ready,
        output ir_write, pc_write, alu_op, alu_src, mem_read, mem_write,
               mem_to_reg, reg_write, br_valid, br_code, state, busy,
               instr_done, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB.
// Control outputs are registered and decoded from the next state, so each
// strobe lines up exactly with the state it belongs to.
// Optional feature MC_MEM_WAIT_EN: MEM dwells until mem_ready is sampled high.
// Without it, MEM lasts exactly one cycle and mem_ready is ignored.
module multicycle_control #(
    parameter int OPW  = 6,
    parameter int ALUW = 3
) (
    input logic                clk,
    input logic                rst,
    multicycle_control_if.slave bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;

    typedef struct packed {
        logic       legal;
        logic       wb;     // ALU or shift op that writes back
        logic       lw;
        logic       sw;
        logic       br;
        logic       src;
        logic [2:0] alu;
    } dec_t;

    // Opcode classifier. Any nonzero bit above bit 5 makes the opcode illegal.
    function automatic dec_t decode(input logic [OPW-1:0] op);
        dec_t       d;
        logic [5:0] lo;
        d  = '0;
        lo = op[5:0];
        if ((op >> 6) == '0) begin
            d.legal = 1'b1;
            case (lo)
                6'b000000: begin d.wb = 1'b1;                              end
                6'b000001: begin d.wb = 1'b1; d.src = 1'b1;                end
                6'b000010: begin d.wb = 1'b1;               d.alu = 3'd1;  end
                6'b000011: begin d.wb = 1'b1; d.src = 1'b1; d.alu = 3'd1;  end
                6'b000100: begin d.wb = 1'b1;               d.alu = 3'd2;  end
                6'b000101: begin d.wb = 1'b1;               d.alu = 3'd3;  end
                6'b001000: begin d.lw = 1'b1; d.src = 1'b1;                end
                6'b001001: begin d.sw = 1'b1; d.src = 1'b1;                end
                6'b001100: begin d.wb = 1'b1; d.src = 1'b1; d.alu = 3'd4;  end
                6'b001101: begin d.wb = 1'b1; d.src = 1'b1; d.alu = 3'd5;  end
                6'b001110: begin d.wb = 1'b1; d.src = 1'b1; d.alu = 3'd4;  end
                6'b010000: begin d.wb = 1'b1; d.src = 1'b1; d.alu = 3'd5;  end
                6'b010001: begin d.wb = 1'b1; d.src = 1'b1; d.alu = 3'd6;  end
                6'b010010: begin d.wb = 1'b1; d.src = 1'b1; d.alu = 3'd6;  end
                default: begin
                    if (lo >= 6'b010100 && lo <= 6'b011111) d.br = 1'b1;
                    else                                    d.legal = 1'b0;
                end
            endcase
        end
        return d;
    endfunction

    logic [2:0]      state;
    logic [2:0]      state_nx;
    logic [2:0]      fin;
    logic [OPW-1:0]  op_q;
    logic [OPW-1:0]  op_d;
    dec_t            dec_d;
    logic            mem_go;

    logic            ir_write_q,  ir_write_nx;
    logic            pc_write_q,  pc_write_nx;
    logic [ALUW-1:0] alu_op_q,    alu_op_nx;
    logic            alu_src_q,   alu_src_nx;
    logic            mem_read_q,  mem_read_nx;
    logic            mem_write_q, mem_write_nx;
    logic            mem_to_reg_q, mem_to_reg_nx;
    logic            reg_write_q, reg_write_nx;
    logic            br_valid_q,  br_valid_nx;
    logic [3:0]      br_code_q,   br_code_nx;
    logic            done_q,      done_nx;
    logic            illegal_q,   illegal_nx;

    // While in FETCH the live opcode is the one about to be latched.
    assign op_d  = (state == S_FETCH) ? bus.opcode : op_q;
    assign dec_d = decode(op_d);

`ifdef MC_MEM_WAIT_EN
    dec_t dec_q;
    assign dec_q  = decode(op_q);
    assign mem_go = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_go           = 1'b1;
`endif

    // State register and opcode latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nx;
            if (state == S_FETCH) op_q <= bus.opcode;
        end
    end

    // Next-state logic; run only matters at instruction boundaries
    always_comb begin
        fin      = bus.run ? S_FETCH : S_IDLE;
        state_nx = S_IDLE;
        case (state)
            S_IDLE:   state_nx = bus.run ? S_FETCH : S_IDLE;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: state_nx = dec_d.legal ? S_EXEC : fin;
            S_EXEC: begin
                if (dec_d.lw || dec_d.sw) state_nx = S_MEM;
                else if (dec_d.wb)        state_nx = S_WB;
                else                      state_nx = fin;
            end
            S_MEM: begin
                if (!mem_go)       state_nx = S_MEM;
                else if (dec_d.lw) state_nx = S_WB;
                else               state_nx = fin;
            end
            S_WB:     state_nx = fin;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Output decode from the state being entered and its opcode
    always_comb begin
        ir_write_nx   = 1'b0;
        pc_write_nx   = 1'b0;
        alu_op_nx     = '0;
        alu_src_nx    = 1'b0;
        mem_read_nx   = 1'b0;
        mem_write_nx  = 1'b0;
        mem_to_reg_nx = 1'b0;
        reg_write_nx  = 1'b0;
        br_valid_nx   = 1'b0;
        br_code_nx    = 4'd0;
        done_nx       = 1'b0;
        illegal_nx    = 1'b0;
        case (state_nx)
            S_FETCH: begin
                ir_write_nx = 1'b1;
                pc_write_nx = 1'b1;
            end
            S_DECODE: begin
                illegal_nx = ~dec_d.legal;
                done_nx    = ~dec_d.legal;
            end
            S_EXEC: begin
                alu_op_nx  = ALUW'(dec_d.alu);
                alu_src_nx = dec_d.src;
                if (dec_d.br) begin
                    br_valid_nx = 1'b1;
                    br_code_nx  = op_d[3:0] - 4'd4;
                    done_nx     = 1'b1;
                end
            end
            S_MEM: begin
                mem_read_nx  = dec_d.lw;
                mem_write_nx = dec_d.sw;
`ifndef MC_MEM_WAIT_EN
                done_nx      = dec_d.sw;
`endif
            end
            S_WB: begin
                reg_write_nx  = 1'b1;
                mem_to_reg_nx = dec_d.lw;
                done_nx       = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs, cleared immediately on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_write_q   <= 1'b0;
            pc_write_q   <= 1'b0;
            alu_op_q     <= '0;
            alu_src_q    <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            br_valid_q   <= 1'b0;
            br_code_q    <= 4'd0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            ir_write_q   <= ir_write_nx;
            pc_write_q   <= pc_write_nx;
            alu_op_q     <= alu_op_nx;
            alu_src_q    <= alu_src_nx;
            mem_read_q   <= mem_read_nx;
            mem_write_q  <= mem_write_nx;
            mem_to_reg_q <= mem_to_reg_nx;
            reg_write_q  <= reg_write_nx;
            br_valid_q   <= br_valid_nx;
            br_code_q    <= br_code_nx;
            done_q       <= done_nx;
            illegal_q    <= illegal_nx;
        end
    end

    assign bus.ir_write   = ir_write_q;
    assign bus.pc_write   = pc_write_q;
    assign bus.alu_op     = alu_op_q;
    assign bus.alu_src    = alu_src_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_to_reg = mem_to_reg_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.br_valid   = br_valid_q;
    assign bus.br_code    = br_code_q;
    assign bus.state      = state;
    assign bus.busy       = (state != S_IDLE);
    assign bus.illegal    = illegal_q;
`ifdef MC_MEM_WAIT_EN
    // A waiting sw only learns it is in its last MEM cycle when mem_ready arrives.
    assign bus.instr_done = done_q | ((state == S_MEM) & dec_q.sw & bus.mem_ready);
`else
    assign bus.instr_done = done_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Expected per-cycle output vectors are
// queued as each instruction is issued and popped as the DUT steps through it.
// Builds with or without MC_MEM_WAIT_EN.
module tb_multicycle_control;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    multicycle_control_if #(.OPW(6), .ALUW(3)) bus ();

    multicycle_control #(.OPW(6), .ALUW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [20:0] v;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [20:0] obs();
        return {bus.state, bus.ir_write, bus.pc_write, bus.alu_op, bus.alu_src,
                bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.reg_write,
                bus.br_valid, bus.br_code, bus.busy, bus.instr_done, bus.illegal};
    endfunction

    function automatic logic [20:0] ex(input logic [2:0] st, input logic [1:0] irpc,
                                       input logic [2:0] aop, input logic src,
                                       input logic [1:0] mrw, input logic m2r,
                                       input logic rw, input logic bv,
                                       input logic [3:0] bc, input logic done,
                                       input logic ill);
        return {st, irpc, aop, src, mrw, m2r, rw, bv, bc, (st != 3'd0), done, ill};
    endfunction

    function automatic logic [20:0] r_idle();
        return ex(3'd0, 2'b00, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] r_f();
        return ex(3'd1, 2'b11, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endfunction
    function automatic logic [20:0] r_d(input logic ill);
        return ex(3'd2, 2'b00, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0, ill, ill);
    endfunction
    function automatic logic [20:0] r_e(input logic [2:0] aop, input logic src,
                                        input logic bv, input logic [3:0] bc);
        return ex(3'd3, 2'b00, aop, src, 2'b00, 1'b0, 1'b0, bv, bc, bv, 1'b0);
    endfunction
    function automatic logic [20:0] r_m(input logic [1:0] mrw, input logic done);
        return ex(3'd4, 2'b00, 3'd0, 1'b0, mrw, 1'b0, 1'b0, 1'b0, 4'd0, done, 1'b0);
    endfunction
    function automatic logic [20:0] r_w(input logic m2r);
        return ex(3'd5, 2'b00, 3'd0, 1'b0, 2'b00, m2r, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic push(input string tag, input logic [20:0] v);
        exp_t t;
        t.tag = tag;
        t.v   = v;
        exp_q.push_back(t);
    endtask

    task automatic step(input int n);
        exp_t t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL underflow: observed %h expected a queued entry", obs());
            end else begin
                t = exp_q.pop_front();
                check(t.tag, obs(), t.v);
            end
        end
    endtask

    int alu_opc [10] = '{6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001100,
                         6'b001101, 6'b001110, 6'b010000, 6'b010001, 6'b010010};
    int alu_exp [10] = '{1, 1, 2, 3, 4, 5, 4, 5, 6, 6};
    int alu_src [10] = '{0, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    int br_opc  [3]  = '{6'b010100, 6'b010111, 6'b011111};
    int br_exp  [3]  = '{0, 3, 11};
    int ill_opc [6]  = '{6'b000111, 6'b000110, 6'b001111, 6'b010011, 6'b100000, 6'b111111};

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;

        // reset state, including with run held high during reset
        @(negedge clk);
        @(negedge clk);
        check("reset", obs(), r_idle());
        bus.run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_run_held", obs(), r_idle());
        bus.run = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_no_run", obs(), r_idle());

        // add: FETCH, DECODE, EXEC, WB
        bus.run    = 1'b1;
        bus.opcode = 6'b000000;
        push("add_F", r_f());
        push("add_D", r_d(1'b0));
        push("add_E", r_e(3'd0, 1'b0, 1'b0, 4'd0));
        push("add_W", r_w(1'b0));
        step(4);

        // lw with mem_ready low for the first three MEM cycles
        bus.opcode    = 6'b001000;
        bus.mem_ready = 1'b0;
        push("lw_F", r_f());
        push("lw_D", r_d(1'b0));
        push("lw_E", r_e(3'd0, 1'b1, 1'b0, 4'd0));
`ifdef MC_MEM_WAIT_EN
        for (int i = 0; i < 4; i++) push($sformatf("lw_M%0d", i), r_m(2'b10, 1'b0));
        push("lw_W", r_w(1'b1));
        step(7);
        bus.mem_ready = 1'b1;
        step(1);
`else
        push("lw_M", r_m(2'b10, 1'b0));
        push("lw_W", r_w(1'b1));
        step(5);
        bus.mem_ready = 1'b1;
`endif

        // ALU and shift mapping table
        for (int i = 0; i < 10; i++) begin
            bus.opcode = alu_opc[i][5:0];
            push($sformatf("alu%0d_F", i), r_f());
            push($sformatf("alu%0d_D", i), r_d(1'b0));
            push($sformatf("alu%0d_E", i), r_e(alu_exp[i][2:0], alu_src[i][0], 1'b0, 4'd0));
            push($sformatf("alu%0d_W", i), r_w(1'b0));
            step(4);
        end

        // branches, including both ends of the range
        for (int i = 0; i < 3; i++) begin
            bus.opcode = br_opc[i][5:0];
            push($sformatf("br%0d_F", i), r_f());
            push($sformatf("br%0d_D", i), r_d(1'b0));
            push($sformatf("br%0d_E", i), r_e(3'd0, 1'b0, 1'b1, br_exp[i][3:0]));
            step(3);
        end

        // illegal opcodes end in DECODE
        for (int i = 0; i < 6; i++) begin
            bus.opcode = ill_opc[i][5:0];
            push($sformatf("ill%0d_F", i), r_f());
            push($sformatf("ill%0d_D", i), r_d(1'b1));
            step(2);
        end

        // sw with mem_ready already high: single MEM cycle, ends there
        bus.opcode = 6'b001001;
        push("sw_F", r_f());
        push("sw_D", r_d(1'b0));
        push("sw_E", r_e(3'd0, 1'b1, 1'b0, 4'd0));
        push("sw_M", r_m(2'b01, 1'b1));
        step(4);

        // addi with run dropped during EXEC: completes, then IDLE
        bus.opcode = 6'b000001;
        push("addi_F", r_f());
        push("addi_D", r_d(1'b0));
        push("addi_E", r_e(3'd0, 1'b1, 1'b0, 4'd0));
        step(3);
        bus.run = 1'b0;
        push("addi_W", r_w(1'b0));
        push("addi_idle0", r_idle());
        push("addi_idle1", r_idle());
        step(3);

        // reset asserted while in MEM with mem_write high
        bus.run       = 1'b1;
        bus.opcode    = 6'b001001;
        bus.mem_ready = 1'b0;
        push("swr_F", r_f());
        push("swr_D", r_d(1'b0));
        push("swr_E", r_e(3'd0, 1'b1, 1'b0, 4'd0));
`ifdef MC_MEM_WAIT_EN
        push("swr_M", r_m(2'b01, 1'b0));
`else
        push("swr_M", r_m(2'b01, 1'b1));
`endif
        step(4);
        rst = 1'b1;
        #1;
        check("rst_async", obs(), r_idle());
        @(posedge clk);
        @(negedge clk);
        check("rst_hold", obs(), r_idle());
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;
        push("post_F", r_f());
        step(1);
        bus.run = 1'b0;
        push("post_D", r_d(1'b0));
        push("post_E", r_e(3'd0, 1'b0, 1'b0, 4'd0));
        push("post_W", r_w(1'b0));
        push("post_idle", r_idle());
        step(4);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain: observed %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
